// File: rtl/proc_pkg.sv
// -----------------------------------------------------------------------------
// proc_pkg
// Shared encodings for the TinyRV1 pipeline control unit.
//   - RV32 opcode / funct3 / funct7 constants for the decoded subset
//   - pc_sel, byp_sel, alu_fn, imm_type and operand-select encodings
//   - dec_ctl_t : control bundle produced by proc_decode for the D stage
//   - x_ctl_t / m_ctl_t / w_ctl_t : per-stage pipeline control registers
//   - byp_select : bypass source chooser shared by both operands
// -----------------------------------------------------------------------------
package proc_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_LW   = 3'b010;
   localparam logic [2:0] F3_SW   = 3'b010;
   localparam logic [2:0] F3_JALR = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;

   localparam logic [6:0] F7_ADD = 7'b0000000;
   localparam logic [6:0] F7_MUL = 7'b0000001;

   localparam logic [1:0] PC_SEL_PLUS4 = 2'd0;
   localparam logic [1:0] PC_SEL_JAL   = 2'd1;
   localparam logic [1:0] PC_SEL_JR    = 2'd2;
   localparam logic [1:0] PC_SEL_BR    = 2'd3;

   localparam logic [1:0] BYP_RF = 2'd0;
   localparam logic [1:0] BYP_X  = 2'd1;
   localparam logic [1:0] BYP_M  = 2'd2;
   localparam logic [1:0] BYP_W  = 2'd3;

   localparam logic [1:0] ALU_ADD = 2'd0;
   localparam logic [1:0] ALU_EQ  = 2'd1;

   localparam logic [1:0] IMM_I = 2'd0;
   localparam logic [1:0] IMM_S = 2'd1;
   localparam logic [1:0] IMM_B = 2'd2;
   localparam logic [1:0] IMM_J = 2'd3;

   localparam logic OP1_RS1 = 1'b0;
   localparam logic OP1_PC  = 1'b1;
   localparam logic OP2_RS2 = 1'b0;
   localparam logic OP2_IMM = 1'b1;

   localparam logic RES_ALU = 1'b0;
   localparam logic RES_MUL = 1'b1;
   localparam logic WB_RES  = 1'b0;
   localparam logic WB_LOAD = 1'b1;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       rs1_used;
      logic       rs2_used;
      logic       rf_wen;
      logic       is_load;
      logic       is_store;
      logic       is_bne;
      logic       is_jal;
      logic       is_jr;
      logic       op1_sel;
      logic       op2_sel;
      logic [1:0] imm_type;
      logic [1:0] alu_fn;
      logic       result_sel;
      logic       wb_sel;
   } dec_ctl_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       rf_wen;
      logic       is_load;
      logic       is_store;
      logic       is_bne;
      logic [1:0] alu_fn;
      logic       result_sel;
      logic       wb_sel;
   } x_ctl_t;

   // M and W keep only the fields still consulted at or after that stage.
   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       rf_wen;
      logic       is_load;
      logic       is_store;
      logic       is_bne;
      logic       wb_sel;
   } m_ctl_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       rf_wen;
      logic       is_store;
      logic       is_bne;
   } w_ctl_t;

   // Youngest in-flight writer wins; x0 always reads the register file.
   function automatic logic [1:0] byp_select(
      input logic [4:0] rs,
      input logic       wr_x, input logic [4:0] rd_x,
      input logic       wr_m, input logic [4:0] rd_m,
      input logic       wr_w, input logic [4:0] rd_w
   );
      logic [1:0] sel;
      sel = BYP_RF;
      if (rs != 5'd0) begin
         if (wr_x && rd_x == rs)      sel = BYP_X;
         else if (wr_m && rd_m == rs) sel = BYP_M;
         else if (wr_w && rd_w == rs) sel = BYP_W;
      end
      return sel;
   endfunction

endpackage

// File: rtl/proc_decode.sv
// -----------------------------------------------------------------------------
// proc_decode
// Purely combinational TinyRV1 decoder: ADD, ADDI, MUL, LW, SW, JAL, JR, BNE.
// Anything else decodes to an all-zero bundle, i.e. a NOP that writes nothing
// and makes no memory request.
//   inst : input  [31:0] raw instruction from the F/D register
//   ctl  : output dec_ctl_t control bundle for the D stage
// -----------------------------------------------------------------------------
module proc_decode
   import proc_pkg::*;
(
   input  logic [31:0] inst,
   output dec_ctl_t    ctl
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = inst[6:0];
   assign funct3 = inst[14:12];
   assign funct7 = inst[31:25];

   // Start from the NOP bundle, then light up the fields each legal
   // instruction needs. Register fields are always passed through; the
   // *_used flags say whether the hazard logic should care about them.
   always_comb begin
      ctl     = '0;
      ctl.rs1 = inst[19:15];
      ctl.rs2 = inst[24:20];
      ctl.rd  = inst[11:7];
      unique case (opcode)
         OPC_OP: begin
            if (funct3 == F3_ADD && funct7 == F7_ADD) begin
               ctl.rs1_used = 1'b1;
               ctl.rs2_used = 1'b1;
               ctl.rf_wen   = 1'b1;
            end else if (funct3 == F3_ADD && funct7 == F7_MUL) begin
               ctl.rs1_used   = 1'b1;
               ctl.rs2_used   = 1'b1;
               ctl.rf_wen     = 1'b1;
               ctl.result_sel = RES_MUL;
            end
         end
         OPC_OPIMM: begin
            if (funct3 == F3_ADD) begin
               ctl.rs1_used = 1'b1;
               ctl.rf_wen   = 1'b1;
               ctl.op2_sel  = OP2_IMM;
               ctl.imm_type = IMM_I;
            end
         end
         OPC_LOAD: begin
            if (funct3 == F3_LW) begin
               ctl.rs1_used = 1'b1;
               ctl.rf_wen   = 1'b1;
               ctl.is_load  = 1'b1;
               ctl.op2_sel  = OP2_IMM;
               ctl.imm_type = IMM_I;
               ctl.wb_sel   = WB_LOAD;
            end
         end
         OPC_STORE: begin
            if (funct3 == F3_SW) begin
               ctl.rs1_used = 1'b1;
               ctl.rs2_used = 1'b1;
               ctl.is_store = 1'b1;
               ctl.op2_sel  = OP2_IMM;
               ctl.imm_type = IMM_S;
            end
         end
         OPC_JAL: begin
            ctl.rf_wen   = 1'b1;
            ctl.is_jal   = 1'b1;
            ctl.op1_sel  = OP1_PC;
            ctl.op2_sel  = OP2_IMM;
            ctl.imm_type = IMM_J;
         end
         OPC_JALR: begin
            if (funct3 == F3_JALR) begin
               ctl.rs1_used = 1'b1;
               ctl.is_jr    = 1'b1;
               ctl.imm_type = IMM_I;
            end
         end
         OPC_BRANCH: begin
            if (funct3 == F3_BNE) begin
               ctl.rs1_used = 1'b1;
               ctl.rs2_used = 1'b1;
               ctl.is_bne   = 1'b1;
               ctl.alu_fn   = ALU_EQ;
               ctl.imm_type = IMM_B;
            end
         end
         default: ctl.rd = inst[11:7];
      endcase
   end

endmodule

// File: rtl/proc_ctrl.sv
// -----------------------------------------------------------------------------
// proc_ctrl
// Control unit for a 5-stage (F D X M W) TinyRV1 pipeline. Decodes the F/D
// instruction, tracks D/X/M/W control state, and produces bypass, stall,
// squash and redirect controls for the datapath.
//   clk, rst                 : clock, synchronous active-high reset
//   d2c_inst, d2c_eq         : F/D instruction, ALU equality of X instruction
//   c2d_reg_en_F/_D          : PC and F/D register enables
//   c2d_pc_sel_F             : next-PC select
//   c2d_op*_byp_sel_D        : operand bypass selects
//   c2d_op*_sel_D, imm_type  : operand / immediate selects
//   c2d_alu_fn_X, result_sel : X-stage function and result select
//   c2d_wb_sel_M, dmemreq_*  : M-stage writeback select and memory request
//   c2d_rf_wen_W, rf_waddr_W : register file write port
//   c2d_imemreq_val          : instruction fetch request valid
// -----------------------------------------------------------------------------
module proc_ctrl
   import proc_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] d2c_inst,
   input  logic        d2c_eq,
   output logic        c2d_reg_en_F,
   output logic        c2d_reg_en_D,
   output logic [1:0]  c2d_pc_sel_F,
   output logic [1:0]  c2d_op1_byp_sel_D,
   output logic [1:0]  c2d_op2_byp_sel_D,
   output logic        c2d_op1_sel_D,
   output logic        c2d_op2_sel_D,
   output logic [1:0]  c2d_imm_type_D,
   output logic [1:0]  c2d_alu_fn_X,
   output logic        c2d_result_sel_X,
   output logic        c2d_wb_sel_M,
   output logic        c2d_dmemreq_val_M,
   output logic        c2d_dmemreq_type_M,
   output logic        c2d_rf_wen_W,
   output logic [4:0]  c2d_rf_waddr_W,
   output logic        c2d_imemreq_val
);

   dec_ctl_t dec_D;
   logic     val_D;
   x_ctl_t   ctl_X;
   x_ctl_t   next_X;
   m_ctl_t   ctl_M;
   w_ctl_t   ctl_W;
   logic     load_use_D;
   logic     bne_taken_X;
   logic     jump_D;
   logic     stall_D;
   logic     squash_F;

   proc_decode u_decode (
      .inst (d2c_inst),
      .ctl  (dec_D)
   );

   // Hazard detection. A taken BNE in X outranks everything in D: the D
   // instruction is squashed anyway, so neither its jump nor its load-use
   // stall may take effect that cycle.
   always_comb begin
      bne_taken_X = ctl_X.valid & ctl_X.is_bne & ~d2c_eq;
      jump_D      = val_D & (dec_D.is_jal | dec_D.is_jr);
      load_use_D  = val_D & ctl_X.valid & ctl_X.is_load & (ctl_X.rd != 5'd0) &
                    ((dec_D.rs1_used & (dec_D.rs1 == ctl_X.rd)) |
                     (dec_D.rs2_used & (dec_D.rs2 == ctl_X.rd)));
      stall_D     = load_use_D & ~bne_taken_X;
      squash_F    = bne_taken_X | (jump_D & ~stall_D);
   end

   // Build the next X entry: a bubble whenever D is empty, stalled, or being
   // squashed by a taken branch.
   always_comb begin
      next_X = '0;
      if (val_D && !stall_D && !bne_taken_X) begin
         next_X.valid      = 1'b1;
         next_X.rd         = dec_D.rd;
         next_X.rf_wen     = dec_D.rf_wen;
         next_X.is_load    = dec_D.is_load;
         next_X.is_store   = dec_D.is_store;
         next_X.is_bne     = dec_D.is_bne;
         next_X.alu_fn     = dec_D.alu_fn;
         next_X.result_sel = dec_D.result_sel;
         next_X.wb_sel     = dec_D.wb_sel;
      end
   end

   // Pipeline registers. X->M->W always advance; only D holds during a
   // load-use stall. Reset wipes every stage so nothing in flight can write
   // the register file or touch memory after the reset edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         val_D <= 1'b0;
         ctl_X <= '0;
         ctl_M <= '0;
         ctl_W <= '0;
      end else begin
         if (!stall_D) begin
            val_D <= ~squash_F;
         end
         ctl_X <= next_X;
         ctl_M <= '{valid: ctl_X.valid, rd: ctl_X.rd, rf_wen: ctl_X.rf_wen,
                    is_load: ctl_X.is_load, is_store: ctl_X.is_store,
                    is_bne: ctl_X.is_bne, wb_sel: ctl_X.wb_sel};
         ctl_W <= '{valid: ctl_M.valid, rd: ctl_M.rd, rf_wen: ctl_M.rf_wen,
                    is_store: ctl_M.is_store, is_bne: ctl_M.is_bne};
      end
   end

   // Output drive. While reset is held every control is forced quiet except
   // the two register enables, which stay open so the front end can reload.
   always_comb begin
      c2d_reg_en_F       = 1'b1;
      c2d_reg_en_D       = 1'b1;
      c2d_pc_sel_F       = PC_SEL_PLUS4;
      c2d_op1_byp_sel_D  = BYP_RF;
      c2d_op2_byp_sel_D  = BYP_RF;
      c2d_op1_sel_D      = OP1_RS1;
      c2d_op2_sel_D      = OP2_RS2;
      c2d_imm_type_D     = IMM_I;
      c2d_alu_fn_X       = ALU_ADD;
      c2d_result_sel_X   = RES_ALU;
      c2d_wb_sel_M       = WB_RES;
      c2d_dmemreq_val_M  = 1'b0;
      c2d_dmemreq_type_M = 1'b0;
      c2d_rf_wen_W       = 1'b0;
      c2d_rf_waddr_W     = 5'd0;
      c2d_imemreq_val    = 1'b0;
      if (!rst) begin
         c2d_reg_en_F = ~stall_D;
         c2d_reg_en_D = ~stall_D;
         if (bne_taken_X) begin
            c2d_pc_sel_F = PC_SEL_BR;
         end else if (jump_D && !stall_D) begin
            c2d_pc_sel_F = dec_D.is_jal ? PC_SEL_JAL : PC_SEL_JR;
         end
         c2d_op1_byp_sel_D  = byp_select(dec_D.rs1,
                                 ctl_X.valid & ctl_X.rf_wen, ctl_X.rd,
                                 ctl_M.valid & ctl_M.rf_wen, ctl_M.rd,
                                 ctl_W.valid & ctl_W.rf_wen, ctl_W.rd);
         c2d_op2_byp_sel_D  = byp_select(dec_D.rs2,
                                 ctl_X.valid & ctl_X.rf_wen, ctl_X.rd,
                                 ctl_M.valid & ctl_M.rf_wen, ctl_M.rd,
                                 ctl_W.valid & ctl_W.rf_wen, ctl_W.rd);
         c2d_op1_sel_D      = dec_D.op1_sel;
         c2d_op2_sel_D      = dec_D.op2_sel;
         c2d_imm_type_D     = dec_D.imm_type;
         c2d_alu_fn_X       = ctl_X.alu_fn;
         c2d_result_sel_X   = ctl_X.result_sel;
         c2d_wb_sel_M       = ctl_M.wb_sel;
         c2d_dmemreq_val_M  = ctl_M.valid & (ctl_M.is_load | ctl_M.is_store);
         c2d_dmemreq_type_M = ctl_M.is_store;
         c2d_rf_wen_W       = ctl_W.valid & ctl_W.rf_wen & (ctl_W.rd != 5'd0) &
                              ~ctl_W.is_store & ~ctl_W.is_bne;
         c2d_rf_waddr_W     = ctl_W.rd;
         c2d_imemreq_val    = 1'b1;
      end
   end

endmodule
